// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the external PC register and instruction fetch
// handshake, arbitrating trap/eret/jump/branch redirects with a one-entry pending slot.
module pc_sequencer #(
    parameter int          N            = 15,
    parameter logic [N-1:0] RESET_VECTOR = '0,
    parameter logic [N-1:0] TRAP_VECTOR  = N'(4)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] pc_cur,
    output logic [N-1:0] pc_next,
    output logic         pc_we,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    output logic         instr_valid,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         trap,
    input  logic         eret,
    output logic         flush,
    output logic [N-1:0] epc
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t       state_reg, state_next;
    logic         pend_valid_reg, pend_valid_next;
    logic         pend_trap_reg, pend_trap_next;
    logic [N-1:0] pend_target_reg, pend_target_next;
    logic [N-1:0] epc_reg;

    logic         req_now;
    logic [N-1:0] req_target;
    logic         redir;
    logic [N-1:0] redir_target;
    logic         apply;

    // Redirect sampled this cycle, highest priority first.
    always_comb begin
        req_now = trap | eret | jump | branch_taken;
        if (trap)
            req_target = TRAP_VECTOR;
        else if (eret)
            req_target = epc_reg;
        else if (jump)
            req_target = jump_target;
        else
            req_target = branch_target;
    end

    // A pending trap is sticky; otherwise a fresh redirect supersedes the pending one.
    always_comb begin
        redir        = 1'b0;
        redir_target = pend_target_reg;
        if (pend_valid_reg && pend_trap_reg) begin
            redir = 1'b1;
        end else if (req_now) begin
            redir        = 1'b1;
            redir_target = req_target;
        end else if (pend_valid_reg) begin
            redir = 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_we       = 1'b0;
        pc_next     = pc_cur;
        imem_req    = 1'b0;
        imem_addr   = pc_cur;
        instr_valid = 1'b0;
        flush       = 1'b0;
        apply       = 1'b0;
        case (state_reg)
            BOOT: begin
                pc_we      = 1'b1;
                pc_next    = RESET_VECTOR;
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redir) begin
                        pc_we   = 1'b1;
                        pc_next = redir_target;
                        flush   = 1'b1;
                        apply   = 1'b1;
                    end else if (!stall) begin
                        instr_valid = 1'b1;
                        pc_we       = 1'b1;
                        pc_next     = pc_cur + N'(1);
                    end else begin
                        instr_valid = 1'b1;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_we      = 1'b1;
                    pc_next    = redir_target;
                    flush      = 1'b1;
                    apply      = 1'b1;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_we      = 1'b1;
                    pc_next    = pc_cur + N'(1);
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
        if (!reset_n) begin
            state_next  = BOOT;
            pc_we       = 1'b1;
            pc_next     = RESET_VECTOR;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            flush       = 1'b0;
            apply       = 1'b0;
        end
    end

    always_comb begin
        pend_valid_next  = pend_valid_reg;
        pend_trap_next   = pend_trap_reg;
        pend_target_next = pend_target_reg;
        if (apply) begin
            pend_valid_next = 1'b0;
            pend_trap_next  = 1'b0;
        end else if (req_now && !(pend_valid_reg && pend_trap_reg)) begin
            pend_valid_next  = 1'b1;
            pend_trap_next   = trap;
            pend_target_next = req_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= BOOT;
            pend_valid_reg  <= 1'b0;
            pend_trap_reg   <= 1'b0;
            pend_target_reg <= '0;
            epc_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            pend_valid_reg  <= pend_valid_next;
            pend_trap_reg   <= pend_trap_next;
            pend_target_reg <= pend_target_next;
            if (trap)
                epc_reg <= pc_cur;
        end
    end

    assign epc = epc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected fetch/PC events,
// a negedge monitor pops and compares whenever the DUT asserts pc_we/instr_valid/flush.
module tb_pc_sequencer;

    localparam int N = 15;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] pc_cur = '0;
    logic [N-1:0] pc_next;
    logic         pc_we;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic         instr_valid;
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         jump;
    logic [N-1:0] jump_target;
    logic         trap;
    logic         eret;
    logic         flush;
    logic [N-1:0] epc;

    logic         force_en;
    logic [N-1:0] force_val;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         we;
        logic [N-1:0] nxt;
        logic         iv;
        logic         fl;
        logic         req;
        logic [N-1:0] addr;
        string        name;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.N(N), .RESET_VECTOR(15'h0000), .TRAP_VECTOR(15'h0004)) dut (
        .clk(clk), .reset_n(reset_n), .pc_cur(pc_cur), .pc_next(pc_next),
        .pc_we(pc_we), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .instr_valid(instr_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap(trap), .eret(eret),
        .flush(flush), .epc(epc)
    );

    always #5 clk = ~clk;

    // External PC register, with a bench-side preload to reach corner values.
    always @(posedge clk) begin
        if (force_en)
            pc_cur <= force_val;
        else if (pc_we)
            pc_cur <= pc_next;
    end

    always @(negedge clk) begin
        if (reset_n && (pc_we || instr_valid || flush)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got we=%0b next=%h iv=%0b fl=%0b req=%0b, expected no event",
                         pc_we, pc_next, instr_valid, flush, imem_req);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.we !== pc_we || e.iv !== instr_valid || e.fl !== flush || e.req !== imem_req ||
                    (e.we && e.nxt !== pc_next) || (e.req && e.addr !== imem_addr)) begin
                    bad++;
                    $display("FAIL %s: got we=%0b next=%h iv=%0b fl=%0b req=%0b addr=%h, expected we=%0b next=%h iv=%0b fl=%0b req=%0b addr=%h",
                             e.name, pc_we, pc_next, instr_valid, flush, imem_req, imem_addr,
                             e.we, e.nxt, e.iv, e.fl, e.req, e.addr);
                end else begin
                    $display("txn %s: we=%0b next=%h iv=%0b fl=%0b addr=%h ok",
                             e.name, pc_we, pc_next, instr_valid, flush, imem_addr);
                end
            end
        end
    end

    task automatic push(input string nm, input logic we, input logic [N-1:0] nxt,
                        input logic iv, input logic fl, input logic req, input logic [N-1:0] addr);
        exp_t e;
        e.we = we; e.nxt = nxt; e.iv = iv; e.fl = fl; e.req = req; e.addr = addr; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end else begin
            $display("chk %s: %h ok", nm, act);
        end
    endtask

    task automatic clr();
        imem_ack = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        trap = 1'b0; eret = 1'b0;
        force_en = 1'b0; force_val = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [N-1:0] v);
        clr();
        force_en  = 1'b1;
        force_val = v;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        imem_ack = 1'b1;
        step();
        step();
        #1;
        chk("rst_pc_we", 32'(pc_we), 32'd1);
        chk("rst_pc_next", 32'(pc_next), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_epc", 32'(epc), 32'd0);

        // Boot then four back-to-back acknowledged fetches.
        reset_n = 1'b1;
        push("boot", 1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000);
        step();
        for (int i = 0; i < 4; i++) begin
            push("seq", 1'b1, 15'(i + 1), 1'b1, 1'b0, 1'b1, 15'(i));
            step();
        end

        preload(15'h7FFF);
        clr(); imem_ack = 1'b1;
        push("wrap", 1'b1, 15'h0000, 1'b1, 1'b0, 1'b1, 15'h7FFF);
        step();

        // Stall at ack enters HOLD; three cycles without pc_we, then advance.
        preload(15'h0005);
        clr(); imem_ack = 1'b1; stall = 1'b1;
        push("stall_ack", 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 15'h0005);
        step();
        for (int i = 0; i < 2; i++) begin
            clr(); stall = 1'b1;
            #1;
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_we", 32'(pc_we), 32'd0);
            step();
        end
        clr();
        push("hold_release", 1'b1, 15'h0006, 1'b0, 1'b0, 1'b0, 15'h0000);
        step();

        preload(15'h0008);
        clr(); branch_taken = 1'b1; branch_target = 15'h0020;
        step();
        clr();
        step();
        clr(); imem_ack = 1'b1;
        push("branch_pending", 1'b1, 15'h0020, 1'b0, 1'b1, 1'b1, 15'h0008);
        step();

        preload(15'h0010);
        clr(); imem_ack = 1'b1; trap = 1'b1; jump = 1'b1; jump_target = 15'h0055;
        push("trap_over_jump", 1'b1, 15'h0004, 1'b0, 1'b1, 1'b1, 15'h0010);
        step();
        clr();
        #1;
        chk("epc_after_trap", 32'(epc), 32'h10);
        step();
        clr(); imem_ack = 1'b1; eret = 1'b1;
        push("eret", 1'b1, 15'h0010, 1'b0, 1'b1, 1'b1, 15'h0004);
        step();

        // Pending trap must survive a later jump.
        clr(); trap = 1'b1;
        step();
        clr(); jump = 1'b1; jump_target = 15'h0066;
        step();
        clr(); imem_ack = 1'b1;
        push("pending_trap_sticky", 1'b1, 15'h0004, 1'b0, 1'b1, 1'b1, 15'h0010);
        step();

        clr(); branch_taken = 1'b1; branch_target = 15'h0030;
        step();
        clr(); jump = 1'b1; jump_target = 15'h0040;
        step();
        clr(); imem_ack = 1'b1;
        push("pending_overwrite", 1'b1, 15'h0040, 1'b0, 1'b1, 1'b1, 15'h0004);
        step();

        clr(); imem_ack = 1'b1; eret = 1'b1; jump = 1'b1; jump_target = 15'h0011;
        push("eret_over_jump", 1'b1, 15'h0010, 1'b0, 1'b1, 1'b1, 15'h0040);
        step();

        // Reset while a jump is pending: the jump must be dropped.
        clr(); jump = 1'b1; jump_target = 15'h0077;
        step();
        clr(); reset_n = 1'b0; imem_ack = 1'b1;
        #1;
        chk("rst2_pc_we", 32'(pc_we), 32'd1);
        chk("rst2_pc_next", 32'(pc_next), 32'd0);
        chk("rst2_imem_req", 32'(imem_req), 32'd0);
        step();
        clr(); reset_n = 1'b1;
        push("boot2", 1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000);
        #1;
        chk("rst2_epc", 32'(epc), 32'd0);
        step();
        clr(); imem_ack = 1'b1;
        push("after_reset", 1'b1, 15'h0001, 1'b1, 1'b0, 1'b1, 15'h0000);
        step();
        clr(); imem_ack = 1'b1; eret = 1'b1;
        push("eret_epc_zero", 1'b1, 15'h0000, 1'b0, 1'b1, 1'b1, 15'h0001);
        step();

        clr();
        step();
        step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, 15, PC and address width in bits.
REQ-002 Parameter RESET_VECTOR, 0, PC value loaded after reset.
REQ-003 Parameter TRAP_VECTOR, 4, PC value loaded on trap.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 pc_cur  in  N  current PC register value.
REQ-007 pc_next  out  N  value for PC register to load.
REQ-008 pc_we  out  1  PC register write enable.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 imem_addr  out  N  fetch address.
REQ-011 imem_ack  in  1  fetch complete; ignored unless imem_req=1.
REQ-012 instr_valid  out  1  fetched instruction accepted for decode.
REQ-013 stall  in  1  downstream cannot advance.
REQ-014 branch_taken, branch_target  in  1, N  branch redirect pulse and target.
REQ-015 jump, jump_target  in  1, N  jump redirect pulse and target.
REQ-016 trap, eret  in  1, 1  exception entry and exception return pulses.
REQ-017 flush  out  1  pulse when a redirect is applied.
REQ-018 epc  out  N  saved exception PC, registered.

Function
REQ-019 States: BOOT, FETCH, HOLD.
REQ-020 BOOT: pc_we=1, pc_next=RESET_VECTOR, imem_req=0; next state FETCH.
REQ-021 FETCH: imem_req=1, imem_addr=pc_cur; imem_addr stays stable from request until imem_ack.
REQ-022 Redirect priority, same cycle: trap > eret > jump > branch_taken.
REQ-023 Redirect targets: trap -> TRAP_VECTOR; eret -> epc; jump -> jump_target; branch -> branch_target.
REQ-024 Trap also loads epc <= pc_cur on the cycle it is sampled.
REQ-025 Redirect not applicable in the sampling cycle: stored in a pending register (valid + target).
REQ-026 A later redirect overwrites the pending one, except a pending trap, which only reset clears.
REQ-027 FETCH, imem_ack=1, redirect present or pending:
- pc_we=1, pc_next=redirect target, flush=1, instr_valid=0.
- Pending cleared; stay FETCH.
REQ-028 FETCH, imem_ack=1, no redirect, stall=0:
- instr_valid=1, pc_we=1, pc_next=pc_cur+1 mod 2^N; stay FETCH.
REQ-029 FETCH, imem_ack=1, no redirect, stall=1: instr_valid=1, pc_we=0; go HOLD.
REQ-030 FETCH, imem_ack=0: pc_we=0, instr_valid=0, flush=0; stay FETCH.
REQ-031 HOLD: imem_req=0.
- Redirect present or pending: pc_we=1, pc_next=target, flush=1, go FETCH (independent of stall).
- Else stall=0: pc_we=1, pc_next=pc_cur+1 mod 2^N, go FETCH.
- Else: pc_we=0, remain HOLD.
REQ-032 Latency: consecutive acks give one fetch per cycle; the next request starts the cycle after pc_we.
REQ-033 Sequential increment wraps 2^N-1 -> 0 with no flag.
REQ-034 flush, pc_we, instr_valid: never asserted in BOOT except pc_we per REQ-020.
REQ-035 eret with epc unwritten since reset: target 0.

Reset
REQ-036 reset_n=0 at a rising edge:
- state <= BOOT; pending cleared; epc <= 0.
- Any in-flight fetch abandoned; a later imem_ack is ignored until FETCH is re-entered.
REQ-037 While reset_n=0, outputs follow BOOT values (REQ-020).

Verification
REQ-038 The bench SHALL cover:
- Reset release, RESET_VECTOR=0, imem_ack=1 every cycle -> imem_addr 0,1,2,3; instr_valid=1 each cycle.
- pc_cur=0x7FFF, ack, stall=0 -> pc_next=0x0000, pc_we=1.
- pc_cur=5, ack with stall=1 held 3 cycles -> HOLD, pc_we=0 for 3 cycles, then pc_next=6.
- pc_cur=8, branch_taken to 0x20 two cycles before ack -> at ack instr_valid=0, flush=1, pc_next=0x20.
- trap + jump same cycle at pc_cur=0x10 -> pc_next=0x0004, epc=0x10; later eret -> pc_next=0x10.
- reset_n=0 in FETCH with a pending jump -> BOOT, pending lost, next pc_next=RESET_VECTOR.
